interrupt_controller: RTL

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

---
 rtl/interrupt_controller.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/interrupt_controller.sv
// Single-level vectored interrupt controller: arbitrates masked device requests,
// hands one source at a time to the CPU through an INTA/EOI handshake.
module interrupt_controller #(
    parameter int          N_SRC       = 4,
    parameter logic [7:0]  VECTOR_BASE = 8'h20,
    parameter int          ROTATE      = 0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [N_SRC-1:0] INTC_IRQ,
    output logic [N_SRC-1:0] INTC_IACK,
    output logic [N_SRC-1:0] INTC_IEND,
    input  logic [N_SRC-1:0] MASK,
    output logic             CPU_INT,
    input  logic             CPU_INTA,
    input  logic             CPU_EOI,
    output logic [7:0]       CPU_VECTOR,
    output logic [N_SRC-1:0] IN_SERVICE
);

    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PENDING = 3'd1,
        ST_ACK     = 3'd2,
        ST_SERVICE = 3'd3,
        ST_END     = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic               cpu_int_q, cpu_int_d;
    logic [7:0]         vec_q, vec_d;
    logic [N_SRC-1:0]   iack_q, iack_d;
    logic [N_SRC-1:0]   iend_q, iend_d;
    logic [N_SRC-1:0]   insvc_q, insvc_d;

    logic [N_SRC-1:0]   eligible_s;
    logic [N_SRC-1:0]   sel_onehot_s;
    logic [IDX_W-1:0]   winner_s;
    logic               found_s;
    int                 arb_start_s;
    int                 arb_idx_s;

    assign eligible_s = INTC_IRQ & ~MASK;

    // Priority search: from index 0 (fixed) or from the source after the last one served.
    always_comb begin
        winner_s  = '0;
        found_s   = 1'b0;
        arb_idx_s = 0;
        if (ROTATE != 0) begin
            arb_start_s = (int'(last_q) + 1) % N_SRC;
        end else begin
            arb_start_s = 0;
        end
        for (int i = 0; i < N_SRC; i++) begin
            arb_idx_s = (arb_start_s + i) % N_SRC;
            if (!found_s && eligible_s[arb_idx_s]) begin
                found_s  = 1'b1;
                winner_s = IDX_W'(arb_idx_s);
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Next-state logic for the service handshake.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    sel_d   = winner_s;
                    state_d = ST_PENDING;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PENDING: begin
                // INTA wins over a request that drops in the same cycle.
                if (CPU_INTA) begin
                    state_d = ST_ACK;
                end else if (!eligible_s[sel_q]) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_PENDING;
                end
            end
            ST_ACK: begin
                state_d = ST_SERVICE;
            end
            ST_SERVICE: begin
                if (CPU_EOI) begin
                    state_d = ST_END;
                end else begin
                    state_d = ST_SERVICE;
                end
            end
            ST_END: begin
                last_d  = sel_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are computed from the next state so that every port comes straight from a flop.
    always_comb begin
        sel_onehot_s = {{(N_SRC-1){1'b0}}, 1'b1} << sel_d;
        cpu_int_d    = (state_d == ST_PENDING);
        if (state_d == ST_ACK) begin
            iack_d = sel_onehot_s;
        end else begin
            iack_d = '0;
        end
        if (state_d == ST_END) begin
            iend_d = sel_onehot_s;
        end else begin
            iend_d = '0;
        end
        if ((state_d == ST_ACK) || (state_d == ST_SERVICE) || (state_d == ST_END)) begin
            insvc_d = sel_onehot_s;
        end else begin
            insvc_d = '0;
        end
        if (state_d == ST_IDLE) begin
            vec_d = vec_q;
        end else begin
            vec_d = VECTOR_BASE + 8'(sel_d);
        end
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            last_q    <= IDX_W'(N_SRC - 1);
            cpu_int_q <= 1'b0;
            vec_q     <= 8'h00;
            iack_q    <= '0;
            iend_q    <= '0;
            insvc_q   <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            cpu_int_q <= cpu_int_d;
            vec_q     <= vec_d;
            iack_q    <= iack_d;
            iend_q    <= iend_d;
            insvc_q   <= insvc_d;
        end
    end

    assign CPU_INT    = cpu_int_q;
    assign CPU_VECTOR = vec_q;
    assign INTC_IACK  = iack_q;
    assign INTC_IEND  = iend_q;
    assign IN_SERVICE = insvc_q;

endmodule
